// File: rtl/egress_pkt_out.sv
// Egress store-and-forward stage: buffers whole packets, strips the metadata word,
// forwards good packets to output ctrl and discards errored, runt or oversize ones.
module egress_pkt_out #(
    parameter int DATA_AW   = 8,
    parameter int VLD_AW    = 6,
    parameter int AF_MARGIN = 100,
    parameter int MIN_WORDS = 3,
    parameter int MAX_WORDS = 97
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_egress_pkt_wr,
    input  logic [133:0] in_egress_pkt,
    input  logic         in_egress_valid_wr,
    input  logic         in_egress_valid,
    output logic         out_egress_pkt_almostfull,
    output logic         out_outputctrl_pkt_wr,
    output logic [133:0] out_outputctrl_pkt,
    output logic         out_outputctrl_valid_wr,
    output logic         out_outputctrl_valid,
    input  logic         in_outputctrl_pkt_almostfull,
    output logic [31:0]  out_sent_cnt,
    output logic [31:0]  out_drop_cnt
);
    localparam int DDEPTH = 1 << DATA_AW;
    localparam int VDEPTH = 1 << VLD_AW;
    localparam logic [10:0]     MIN_LEN  = 11'(MIN_WORDS);
    localparam logic [10:0]     MAX_LEN  = 11'(MAX_WORDS);
    localparam logic [DATA_AW:0] DEPTH_W = (DATA_AW + 1)'(DDEPTH);
    localparam logic [DATA_AW:0] AF_FREE = (DATA_AW + 1)'(AF_MARGIN);
    localparam logic [VLD_AW:0]  VAF_USED = (VLD_AW + 1)'(VDEPTH - 2);

    typedef enum logic [1:0] {IDLE, META, SEND, DROP} state_t;
    typedef struct packed {
        logic        drop;
        logic [10:0] len;
    } desc_t;

    // Headers are regenerated on the way out, so only the payload is stored.
    logic [131:0] d_mem [DDEPTH];
    logic [131:0] rd_data;
    logic [DATA_AW:0] d_wptr, d_rptr, d_used;
    logic d_full, d_we;

    desc_t v_mem [VDEPTH];
    desc_t desc_in, head;
    logic [VLD_AW:0] v_wptr, v_rptr, v_used;
    logic v_full, v_empty, v_we;

    logic [10:0] wcnt, len_in, cur_len, rcnt, last_idx;
    state_t state, next_state;
    logic pop, rd_en, drop_done, issue, issue_last;
    logic [1:0] issue_hdr;
    logic s1_vld, s1_last;
    logic [1:0] s1_hdr;
    logic unused_hdr;

    assign unused_hdr = ^in_egress_pkt[133:132];

    assign d_used = d_wptr - d_rptr;
    assign d_full = (d_wptr[DATA_AW] != d_rptr[DATA_AW]) &&
                    (d_wptr[DATA_AW-1:0] == d_rptr[DATA_AW-1:0]);
    assign d_we   = in_egress_pkt_wr && !d_full;

    assign v_used  = v_wptr - v_rptr;
    assign v_empty = (v_wptr == v_rptr);
    assign v_full  = (v_wptr[VLD_AW] != v_rptr[VLD_AW]) &&
                     (v_wptr[VLD_AW-1:0] == v_rptr[VLD_AW-1:0]);
    assign v_we    = in_egress_valid_wr && !v_full;
    assign head    = v_mem[v_rptr[VLD_AW-1:0]];

    assign len_in       = (in_egress_pkt_wr && !(&wcnt)) ? wcnt + 11'd1 : wcnt;
    assign desc_in.len  = len_in;
    assign desc_in.drop = !in_egress_valid || (len_in < MIN_LEN) || (len_in > MAX_LEN);
    assign last_idx     = cur_len - 11'd1;

    // NOTE: storage arrays carry no reset; emptiness is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (d_we) d_mem[d_wptr[DATA_AW-1:0]] <= in_egress_pkt[131:0];
        if (v_we) v_mem[v_wptr[VLD_AW-1:0]] <= desc_in;
        if (rd_en) rd_data <= d_mem[d_rptr[DATA_AW-1:0]];
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        rd_en      = 1'b0;
        drop_done  = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_hdr  = 2'b11;
        case (state)
            IDLE: if (!v_empty) begin
                if (head.drop) begin
                    pop        = 1'b1;
                    next_state = DROP;
                end else if (!in_outputctrl_pkt_almostfull) begin
                    pop        = 1'b1;
                    next_state = META;
                end
            end
            META: begin
                rd_en      = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                rd_en      = 1'b1;
                issue      = 1'b1;
                issue_last = (rcnt == last_idx);
                if (rcnt == 11'd1)   issue_hdr = 2'b01;
                else if (issue_last) issue_hdr = 2'b10;
                if (issue_last) next_state = IDLE;
            end
            DROP: begin
                // A zero-length descriptor has nothing to read back.
                if (cur_len == 11'd0) begin
                    drop_done  = 1'b1;
                    next_state = IDLE;
                end else begin
                    rd_en = 1'b1;
                    if (rcnt == last_idx) begin
                        drop_done  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                     <= IDLE;
            d_wptr                    <= '0;
            d_rptr                    <= '0;
            v_wptr                    <= '0;
            v_rptr                    <= '0;
            wcnt                      <= '0;
            cur_len                   <= '0;
            rcnt                      <= '0;
            s1_vld                    <= 1'b0;
            s1_last                   <= 1'b0;
            s1_hdr                    <= 2'b00;
            out_egress_pkt_almostfull <= 1'b0;
            out_outputctrl_pkt_wr     <= 1'b0;
            out_outputctrl_pkt        <= '0;
            out_outputctrl_valid_wr   <= 1'b0;
            out_outputctrl_valid      <= 1'b0;
            out_sent_cnt              <= '0;
            out_drop_cnt              <= '0;
        end else begin
            state <= next_state;
            if (d_we)  d_wptr <= d_wptr + 1'b1;
            if (rd_en) d_rptr <= d_rptr + 1'b1;
            if (v_we)  v_wptr <= v_wptr + 1'b1;
            if (pop)   v_rptr <= v_rptr + 1'b1;

            if (in_egress_valid_wr)                 wcnt <= '0;
            else if (in_egress_pkt_wr && !(&wcnt))  wcnt <= wcnt + 11'd1;

            if (pop) begin
                cur_len <= head.len;
                rcnt    <= '0;
            end else if (rd_en) begin
                rcnt <= rcnt + 11'd1;
            end

            // Stage 1 lines up header/eop with the one-cycle data FIFO read.
            s1_vld  <= issue;
            s1_last <= issue_last;
            s1_hdr  <= issue_hdr;

            out_egress_pkt_almostfull <= ((DEPTH_W - d_used) <= AF_FREE) || (v_used >= VAF_USED);
            out_outputctrl_pkt_wr     <= s1_vld;
            out_outputctrl_pkt        <= s1_vld ? {s1_hdr, rd_data} : '0;
            out_outputctrl_valid_wr   <= s1_vld && s1_last;
            out_outputctrl_valid      <= s1_vld && s1_last;
            if (s1_vld && s1_last) out_sent_cnt <= out_sent_cnt + 32'd1;
            if (drop_done)         out_drop_cnt <= out_drop_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_egress_pkt_out.sv
// Directed bench for egress_pkt_out: forwarding, drops, backpressure, almostfull and reset.
module tb_egress_pkt_out;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_egress_pkt_wr;
    logic [133:0] in_egress_pkt;
    logic         in_egress_valid_wr;
    logic         in_egress_valid;
    logic         out_egress_pkt_almostfull;
    logic         out_outputctrl_pkt_wr;
    logic [133:0] out_outputctrl_pkt;
    logic         out_outputctrl_valid_wr;
    logic         out_outputctrl_valid;
    logic         in_outputctrl_pkt_almostfull;
    logic [31:0]  out_sent_cnt;
    logic [31:0]  out_drop_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_t = 0;

    logic [133:0] got[$];
    int           got_cyc[$];
    logic         got_last[$];
    logic         got_v[$];
    logic [133:0] exp_q[$];
    logic         exp_last[$];

    egress_pkt_out dut (
        .clk                          (clk),
        .reset                        (reset),
        .in_egress_pkt_wr             (in_egress_pkt_wr),
        .in_egress_pkt                (in_egress_pkt),
        .in_egress_valid_wr           (in_egress_valid_wr),
        .in_egress_valid              (in_egress_valid),
        .out_egress_pkt_almostfull    (out_egress_pkt_almostfull),
        .out_outputctrl_pkt_wr        (out_outputctrl_pkt_wr),
        .out_outputctrl_pkt           (out_outputctrl_pkt),
        .out_outputctrl_valid_wr      (out_outputctrl_valid_wr),
        .out_outputctrl_valid         (out_outputctrl_valid),
        .in_outputctrl_pkt_almostfull (in_outputctrl_pkt_almostfull),
        .out_sent_cnt                 (out_sent_cnt),
        .out_drop_cnt                 (out_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_outputctrl_pkt_wr === 1'b1) begin
            got.push_back(out_outputctrl_pkt);
            got_cyc.push_back(cyc);
            got_last.push_back(out_outputctrl_valid_wr);
            got_v.push_back(out_outputctrl_valid);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] mkword(input logic [1:0] h, input int id, input int idx);
        logic [15:0] a;
        logic [15:0] b;
        a = id[15:0];
        b = idx[15:0];
        return {h, 32'hDEADBEEF, 68'h0, a, b};
    endfunction

    // Input headers follow head/middle/tail; valid_wr rides on the tail word.
    task automatic write_words(input int id, input int len, input int lo, input int hi, input logic good);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            in_egress_pkt_wr   = 1'b1;
            in_egress_pkt      = mkword((i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11), id, i);
            in_egress_valid_wr = (i == len - 1);
            in_egress_valid    = good;
        end
        @(negedge clk);
        in_egress_pkt_wr   = 1'b0;
        in_egress_valid_wr = 1'b0;
        in_egress_valid    = 1'b0;
        if (hi == len - 1) last_t = cyc;
    endtask

    // Metadata word is stripped; output index k=1..len-1 gets 01 / 11 / 10.
    task automatic add_exp(input int id, input int len);
        for (int k = 1; k < len; k++) begin
            exp_q.push_back(mkword((k == 1) ? 2'b01 : ((k == len - 1) ? 2'b10 : 2'b11), id, k));
            exp_last.push_back(k == len - 1);
        end
    endtask

    task automatic wait_cnt(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got.size() >= n) break;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        wait_cnt(n, budget);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_q();
        got.delete();
        got_cyc.delete();
        got_last.delete();
        got_v.delete();
        exp_q.delete();
        exp_last.delete();
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, " count"}, 134'(got.size()), 134'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s word%0d", tag, i), got[i], exp_q[i]);
            check($sformatf("%s eop%0d", tag, i), 134'(got_last[i]), 134'(exp_last[i]));
            if (exp_last[i]) check($sformatf("%s valid%0d", tag, i), 134'(got_v[i]), 134'(1'b1));
        end
        clear_q();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset                        = 1'b1;
        in_egress_pkt_wr             = 1'b0;
        in_egress_valid_wr           = 1'b0;
        in_egress_valid              = 1'b0;
        in_outputctrl_pkt_almostfull = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_q();
    endtask

    initial begin
        int lat;
        int gap;
        reset                        = 1'b1;
        in_egress_pkt_wr             = 1'b0;
        in_egress_pkt                = '0;
        in_egress_valid_wr           = 1'b0;
        in_egress_valid              = 1'b0;
        in_outputctrl_pkt_almostfull = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst pkt_wr",  134'(out_outputctrl_pkt_wr), 134'(0));
        check("rst pkt",     out_outputctrl_pkt, 134'(0));
        check("rst valid_wr", 134'(out_outputctrl_valid_wr), 134'(0));
        check("rst valid",   134'(out_outputctrl_valid), 134'(0));
        check("rst af",      134'(out_egress_pkt_almostfull), 134'(0));
        check("rst sent",    134'(out_sent_cnt), 134'(0));
        check("rst drop",    134'(out_drop_cnt), 134'(0));
        reset = 1'b0;
        clear_q();

        // 1: 5-word good packet, first word at T+4
        write_words(1, 5, 0, 4, 1'b1);
        add_exp(1, 5);
        wait_out(4, 50);
        lat = (got.size() > 0) ? got_cyc[0] - last_t : -1;
        check("t1 latency", 134'(lat), 134'(4));
        compare("t1");
        check("t1 sent", 134'(out_sent_cnt), 134'(1));
        check("t1 drop", 134'(out_drop_cnt), 134'(0));

        // 2: errored packet dropped, then a minimum-size good packet stays aligned
        do_reset();
        write_words(2, 4, 0, 3, 1'b0);
        repeat (20) @(negedge clk);
        check("t2 no output", 134'(got.size()), 134'(0));
        check("t2 drop", 134'(out_drop_cnt), 134'(1));
        check("t2 sent0", 134'(out_sent_cnt), 134'(0));
        write_words(3, 3, 0, 2, 1'b1);
        add_exp(3, 3);
        wait_out(2, 50);
        compare("t2 min");
        check("t2 sent1", 134'(out_sent_cnt), 134'(1));

        // 3: runt and oversize dropped, maximum-size packet forwarded
        do_reset();
        write_words(4, 2, 0, 1, 1'b1);
        write_words(5, 98, 0, 97, 1'b1);
        repeat (130) @(negedge clk);
        check("t3 no output", 134'(got.size()), 134'(0));
        check("t3 drop", 134'(out_drop_cnt), 134'(2));
        check("t3 sent", 134'(out_sent_cnt), 134'(0));
        write_words(6, 97, 0, 96, 1'b1);
        add_exp(6, 97);
        wait_out(96, 300);
        compare("t3 max");
        check("t3 sent max", 134'(out_sent_cnt), 134'(1));

        // 4: downstream backpressure holds three queued packets
        do_reset();
        in_outputctrl_pkt_almostfull = 1'b1;
        write_words(10, 3, 0, 2, 1'b1);
        add_exp(10, 3);
        write_words(11, 4, 0, 3, 1'b1);
        add_exp(11, 4);
        write_words(12, 5, 0, 4, 1'b1);
        add_exp(12, 5);
        repeat (20) @(negedge clk);
        check("t4 held", 134'(got.size()), 134'(0));
        in_outputctrl_pkt_almostfull = 1'b0;
        wait_out(9, 100);
        gap = (got.size() >= 9) ? got_cyc[2] - got_cyc[1] : 0;
        check("t4 gap1", 134'(gap >= 2), 134'(1));
        gap = (got.size() >= 9) ? got_cyc[5] - got_cyc[4] : 0;
        check("t4 gap2", 134'(gap >= 2), 134'(1));
        compare("t4");
        check("t4 sent", 134'(out_sent_cnt), 134'(3));

        // 5: almostfull rises exactly at 100 free words, falls after drain
        do_reset();
        in_outputctrl_pkt_almostfull = 1'b1;
        write_words(20, 60, 0, 59, 1'b1);
        add_exp(20, 60);
        repeat (2) @(negedge clk);
        check("t5 af used60", 134'(out_egress_pkt_almostfull), 134'(0));
        write_words(21, 60, 0, 59, 1'b1);
        add_exp(21, 60);
        repeat (2) @(negedge clk);
        check("t5 af used120", 134'(out_egress_pkt_almostfull), 134'(0));
        write_words(22, 60, 0, 34, 1'b1);
        repeat (2) @(negedge clk);
        check("t5 af free101", 134'(out_egress_pkt_almostfull), 134'(0));
        write_words(22, 60, 35, 35, 1'b1);
        repeat (2) @(negedge clk);
        check("t5 af free100", 134'(out_egress_pkt_almostfull), 134'(1));
        write_words(22, 60, 36, 59, 1'b1);
        add_exp(22, 60);
        in_outputctrl_pkt_almostfull = 1'b0;
        wait_out(177, 1000);
        compare("t5");
        check("t5 af drained", 134'(out_egress_pkt_almostfull), 134'(0));
        check("t5 sent", 134'(out_sent_cnt), 134'(3));

        // 6: reset after the second output word, then a fresh packet
        do_reset();
        write_words(30, 5, 0, 4, 1'b1);
        wait_cnt(2, 50);
        reset = 1'b1;
        @(negedge clk);
        check("t6 pkt_wr",   134'(out_outputctrl_pkt_wr), 134'(0));
        check("t6 pkt",      out_outputctrl_pkt, 134'(0));
        check("t6 valid_wr", 134'(out_outputctrl_valid_wr), 134'(0));
        check("t6 valid",    134'(out_outputctrl_valid), 134'(0));
        check("t6 sent",     134'(out_sent_cnt), 134'(0));
        check("t6 drop",     134'(out_drop_cnt), 134'(0));
        check("t6 words before reset", 134'(got.size()), 134'(2));
        reset = 1'b0;
        clear_q();
        write_words(31, 5, 0, 4, 1'b1);
        add_exp(31, 5);
        wait_out(4, 50);
        compare("t6 fresh");
        check("t6 sent fresh", 134'(out_sent_cnt), 134'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
